// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM bank: register map, CTRL bitfields, width type.
// No logic of its own; the clamp helper is purely combinational.
// Nothing in here carries state or flow control.
package servo_pkg;

  // Pulse widths and targets are 12-bit microsecond counts
  typedef logic [11:0] width_t;

  localparam logic [3:0] REG_CTRL    = 4'd0;
  localparam logic [3:0] REG_MASK    = 4'd1;
  localparam logic [3:0] REG_CH_BASE = 4'd2;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_SLEW_LSB = 8;
  localparam int CTRL_SLEW_MSB = 15;

  // Saturate a requested width into [lo, hi]
  function automatic width_t clamp_us(input width_t v, input width_t lo, input width_t hi);
    if (v < lo) return lo;
    else if (v > hi) return hi;
    else return v;
  endfunction

endpackage

// File: rtl/servo_slew_ch.sv
// One servo channel: clamped target, slew-limited current width, pulse compare.
// Target updates on the write cycle; current moves only on the frame strobe.
// No backpressure: writes are always accepted.
module servo_slew_ch
  import servo_pkg::*;
#(
  parameter int MIN_US = 1000,
  parameter int MAX_US = 2000,
  parameter int FW     = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_vld,
  input  width_t        wr_dat,
  input  logic          frame_stb,
  input  logic [7:0]    slew,
  input  logic [FW-1:0] frame_us,
  output width_t        target,
  output width_t        current,
  output logic          pulse
);

  localparam width_t LO  = width_t'(MIN_US);
  localparam width_t HI  = width_t'(MAX_US);
  localparam width_t MID = width_t'((MIN_US + MAX_US) / 2);

  width_t target_q, target_d;
  width_t current_q, current_d;
  width_t diff, step;

  // Clamp on the way in so the stored target is always legal
  always_comb begin
    target_d = target_q;
    if (wr_vld) target_d = clamp_us(wr_dat, LO, HI);
  end

  // Step toward the target by at most slew; difference is checked before adding so nothing wraps
  always_comb begin
    current_d = current_q;
    step      = width_t'(slew);
    diff      = '0;
    if (frame_stb) begin
      if (target_q >= current_q) begin
        diff = target_q - current_q;
        if (slew == '0 || diff <= step) current_d = target_q;
        else                            current_d = current_q + step;
      end else begin
        diff = current_q - target_q;
        if (slew == '0 || diff <= step) current_d = target_q;
        else                            current_d = current_q - step;
      end
    end
  end

  // Width registers restart at mid-travel
  always_ff @(posedge clk) begin
    if (reset) begin
      target_q  <= MID;
      current_q <= MID;
    end else begin
      target_q  <= target_d;
      current_q <= current_d;
    end
  end

  assign target  = target_q;
  assign current = current_q;
  assign pulse   = 32'(frame_us) < 32'(current_q);

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel frame-aligned RC-servo PWM with Avalon-MM register access.
// Read data one cycle after avs_read; servo_out one cycle after the frame compare.
// No waitrequest: every read and write completes in its strobe cycle.
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter int CHANNELS = 6,
  parameter int CLK_HZ   = 50_000_000,
  parameter int FRAME_US = 20000,
  parameter int MIN_US   = 1000,
  parameter int MAX_US   = 2000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic [CHANNELS-1:0] servo_out,
  output logic                frame_start
);

  localparam int PRESC = CLK_HZ / 1_000_000;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int FW    = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_US - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [FW-1:0]       frame_us_q, frame_us_d;
  logic                us_tick, frame_bnd;
  logic                gen_en_q, gen_en_d;
  logic [7:0]          slew_q, slew_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic                sh_en_q, sh_en_d;
  logic [CHANNELS-1:0] sh_mask_q, sh_mask_d;
  logic [CHANNELS-1:0] servo_out_q, servo_out_d;
  logic                frame_start_q, frame_start_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [CHANNELS-1:0] ch_wr, ch_pulse;
  width_t              ch_target  [CHANNELS];
  width_t              ch_current [CHANNELS];
  logic                unused_wdata;

  assign unused_wdata = ^avs_writedata;

  // Microsecond prescaler and frame counter; the boundary is the last tick of the frame
  always_comb begin
    us_tick    = (presc_q == PRESC_LAST);
    frame_bnd  = us_tick && (frame_us_q == FRAME_LAST);
    presc_d    = us_tick ? '0 : presc_q + PW'(1);
    frame_us_d = frame_us_q;
    if (us_tick) frame_us_d = (frame_us_q == FRAME_LAST) ? '0 : frame_us_q + FW'(1);
  end

  // Live CTRL/MASK registers written over Avalon
  always_comb begin
    gen_en_d = gen_en_q;
    slew_d   = slew_q;
    mask_d   = mask_q;
    if (avs_write && avs_address == REG_CTRL) begin
      gen_en_d = avs_writedata[CTRL_EN_BIT];
      slew_d   = avs_writedata[CTRL_SLEW_MSB:CTRL_SLEW_LSB];
    end
    if (avs_write && avs_address == REG_MASK) mask_d = avs_writedata[CHANNELS-1:0];
  end

  // Shadows only move on the boundary so enables never cut a pulse short
  always_comb begin
    sh_en_d       = frame_bnd ? gen_en_q : sh_en_q;
    sh_mask_d     = frame_bnd ? mask_q : sh_mask_q;
    frame_start_d = frame_bnd;
    servo_out_d   = {CHANNELS{sh_en_q}} & sh_mask_q & ch_pulse;
  end

  // Read mux sampled into a holding register; reads see pre-write state
  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      rdata_d = '0;
      if (avs_address == REG_CTRL) rdata_d = {16'b0, slew_q, 7'b0, gen_en_q};
      if (avs_address == REG_MASK) rdata_d[CHANNELS-1:0] = mask_q;
      for (int i = 0; i < CHANNELS; i++) begin
        if (avs_address == REG_CH_BASE + 4'(i))
          rdata_d = {4'b0, ch_current[i], 4'b0, ch_target[i]};
      end
    end
  end

  // All top-level state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q       <= '0;
      frame_us_q    <= '0;
      gen_en_q      <= 1'b0;
      slew_q        <= '0;
      mask_q        <= '0;
      sh_en_q       <= 1'b0;
      sh_mask_q     <= '0;
      servo_out_q   <= '0;
      frame_start_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      presc_q       <= presc_d;
      frame_us_q    <= frame_us_d;
      gen_en_q      <= gen_en_d;
      slew_q        <= slew_d;
      mask_q        <= mask_d;
      sh_en_q       <= sh_en_d;
      sh_mask_q     <= sh_mask_d;
      servo_out_q   <= servo_out_d;
      frame_start_q <= frame_start_d;
      rdata_q       <= rdata_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign ch_wr[i] = avs_write && (avs_address == REG_CH_BASE + 4'(i));

    servo_slew_ch #(
      .MIN_US (MIN_US),
      .MAX_US (MAX_US),
      .FW     (FW)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_vld    (ch_wr[i]),
      .wr_dat    (avs_writedata[11:0]),
      .frame_stb (frame_bnd),
      .slew      (slew_q),
      .frame_us  (frame_us_q),
      .target    (ch_target[i]),
      .current   (ch_current[i]),
      .pulse     (ch_pulse[i])
    );
  end

  assign avs_readdata = rdata_q;
  assign servo_out    = servo_out_q;
  assign frame_start  = frame_start_q;

endmodule
